// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - core-wide shared types
package common;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/pipes_pkg.sv
// rtl/pipes_pkg.sv - pipeline control state, per-stage control bundle and canned control patterns
package pipes;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MD_WAIT     = 2'd1,
    FETCH_DRAIN = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } stage_ctl_t;

  // Field order: stall_f stall_d stall_e stall_m flush_d flush_e flush_m flush_w
  localparam stage_ctl_t CTL_NONE     = 8'b0000_0000;
  localparam stage_ctl_t CTL_FREEZE   = 8'b1111_0001;
  localparam stage_ctl_t CTL_MD       = 8'b1110_0010;
  localparam stage_ctl_t CTL_DRAIN    = 8'b0000_1000;
  localparam stage_ctl_t CTL_REDIRECT = 8'b0000_1100;
  localparam stage_ctl_t CTL_LOAD_USE = 8'b1100_0100;
  localparam stage_ctl_t CTL_FETCH    = 8'b1000_1000;

  // md_cnt only ever holds MD_LAT-1 down to 0; keep at least one bit for MD_LAT==1.
  function automatic int md_cnt_width(input int md_lat);
    return (md_lat > 1) ? $clog2(md_lat) : 1;
  endfunction

endpackage

// File: rtl/md_timer.sv
// rtl/md_timer.sv - mul/div occupancy down-counter and one-shot completion flag
module md_timer
  import pipes::*;
#(
  parameter int MD_LAT = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic freeze_i,
  input  logic start_i,
  input  logic run_i,
  output logic md_last,
  output logic md_done_q
);

  localparam int MC_W = md_cnt_width(MD_LAT);

  logic [MC_W-1:0] md_cnt_q, md_cnt_d;
  logic            md_done_d;

  assign md_last = (md_cnt_q == MC_W'(1));

  always_comb begin
    md_cnt_d  = md_cnt_q;
    md_done_d = 1'b0;
    if (freeze_i) begin
      // done must survive a data-bus freeze so E still sees the result when it moves
      md_done_d = md_done_q;
    end else if (start_i) begin
      if (MD_LAT > 1) md_cnt_d = MC_W'(MD_LAT - 1);
      else            md_done_d = 1'b1;
    end else if (run_i) begin
      md_cnt_d = md_cnt_q - MC_W'(1);
      if (md_last) md_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      md_cnt_q  <= '0;
      md_done_q <= 1'b0;
    end else begin
      md_cnt_q  <= md_cnt_d;
      md_done_q <= md_done_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - five-stage pipeline stall/flush arbiter and fetch redirect
module hazard_ctrl
  import common::*;
  import pipes::*;
#(
  parameter int MD_LAT = 64,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             bubble_rs1,
  input  logic             bubble_rs2,
  input  logic             br_taken_e,
  input  word_t            br_target_e,
  input  logic             imem_busy,
  input  logic             dmem_busy_m,
  input  logic             md_start_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic             redirect_valid,
  output word_t            redirect_pc,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_t      state_q, state_d;
  word_t            redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  stage_ctl_t       ctl;
  logic             md_start, md_run, md_last, md_done_q;

  md_timer #(.MD_LAT(MD_LAT)) u_md_timer (
    .clk       (clk),
    .resetn    (resetn),
    .freeze_i  (dmem_busy_m),
    .start_i   (md_start),
    .run_i     (md_run),
    .md_last   (md_last),
    .md_done_q (md_done_q)
  );

  always_comb begin
    state_d        = state_q;
    redir_pc_d     = redir_pc_q;
    ctl            = CTL_NONE;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    md_start       = 1'b0;
    md_run         = 1'b0;
    // Outputs are combinational, so gate them while reset is asserted.
    if (resetn) begin
      if (dmem_busy_m) begin
        ctl = CTL_FREEZE;
      end else if (state_q == MD_WAIT) begin
        ctl    = CTL_MD;
        md_run = 1'b1;
        if (md_last) state_d = RUN;
      end else if (state_q == FETCH_DRAIN) begin
        ctl            = CTL_DRAIN;
        redirect_valid = 1'b1;
        redirect_pc    = redir_pc_q;
        if (!imem_busy) state_d = RUN;
      end else if (br_taken_e) begin
        // Beats load-use: the dependent instruction in D is squashed anyway.
        ctl            = CTL_REDIRECT;
        redirect_valid = 1'b1;
        redirect_pc    = br_target_e;
        redir_pc_d     = br_target_e;
        if (imem_busy) state_d = FETCH_DRAIN;
      end else if (md_start_e && !md_done_q) begin
        ctl      = CTL_MD;
        md_start = 1'b1;
        if (MD_LAT > 1) state_d = MD_WAIT;
      end else if (bubble_rs1 || bubble_rs2) begin
        ctl = CTL_LOAD_USE;
      end else if (imem_busy) begin
        ctl = CTL_FETCH;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ctl.stall_f && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RUN;
      redir_pc_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      redir_pc_q  <= redir_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_f   = ctl.stall_f;
  assign stall_d   = ctl.stall_d;
  assign stall_e   = ctl.stall_e;
  assign stall_m   = ctl.stall_m;
  assign flush_d   = ctl.flush_d;
  assign flush_e   = ctl.flush_e;
  assign flush_m   = ctl.flush_m;
  assign flush_w   = ctl.flush_w;
  assign md_done   = md_done_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed-vector bench for hazard_ctrl (MD_LAT=4, CNT_W=5)
module tb_hazard_ctrl;
  import common::*;

  localparam int CNT_W = 5;

  // {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_m,flush_w,redirect_valid,md_done}
  localparam logic [9:0] E_NONE  = 10'b0000000000;
  localparam logic [9:0] E_LU    = 10'b1100010000;
  localparam logic [9:0] E_REDIR = 10'b0000110010;
  localparam logic [9:0] E_DRAIN = 10'b0000100010;
  localparam logic [9:0] E_MD    = 10'b1110001000;
  localparam logic [9:0] E_DONE  = 10'b0000000001;
  localparam logic [9:0] E_FZ    = 10'b1111000100;
  localparam logic [9:0] E_FZD   = 10'b1111000101;
  localparam logic [9:0] E_FW    = 10'b1000100000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic bubble_rs1 = 1'b0, bubble_rs2 = 1'b0, br_taken_e = 1'b0;
  logic imem_busy = 1'b0, dmem_busy_m = 1'b0, md_start_e = 1'b0;
  word_t br_target_e = '0;
  logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w;
  logic redirect_valid, md_done;
  word_t redirect_pc;
  logic [CNT_W-1:0] stall_cnt;
  logic [9:0] ctl;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
                redirect_valid, md_done};

  hazard_ctrl #(.MD_LAT(4), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .bubble_rs1     (bubble_rs1),
    .bubble_rs2     (bubble_rs2),
    .br_taken_e     (br_taken_e),
    .br_target_e    (br_target_e),
    .imem_busy      (imem_busy),
    .dmem_busy_m    (dmem_busy_m),
    .md_start_e     (md_start_e),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .stall_e        (stall_e),
    .stall_m        (stall_m),
    .flush_d        (flush_d),
    .flush_e        (flush_e),
    .flush_m        (flush_m),
    .flush_w        (flush_w),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .md_done        (md_done),
    .stall_cnt      (stall_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    imem_busy = 1'b1; bubble_rs1 = 1'b1; br_taken_e = 1'b1; br_target_e = 32'h1234_5678;
    #2;
    vecs++;
    if (ctl !== E_NONE) begin errs++; $display("FAIL reset_ctl got=%b exp=%b", ctl, E_NONE); end
    vecs++;
    if (redirect_pc !== 32'h0) begin errs++; $display("FAIL reset_pc got=%h exp=%h", redirect_pc, 32'h0); end
    vecs++;
    if (stall_cnt !== 5'd0) begin errs++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    imem_busy = 1'b0; bubble_rs1 = 1'b0; br_taken_e = 1'b0; br_target_e = '0;
    step(); step();
    resetn = 1'b1;
  endtask

  task automatic test_load_use();
    bubble_rs1 = 1'b1;
    @(negedge clk);
    vecs++;
    if (ctl !== E_LU) begin errs++; $display("FAIL load_use got=%b exp=%b", ctl, E_LU); end
    step();
    bubble_rs1 = 1'b0;
    @(negedge clk);
    vecs++;
    if (ctl !== E_NONE) begin errs++; $display("FAIL load_use_after got=%b exp=%b", ctl, E_NONE); end
    vecs++;
    if (stall_cnt !== 5'd1) begin errs++; $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt); end
    step();
  endtask

  task automatic test_branch();
    br_taken_e = 1'b1; br_target_e = 32'h8000_0040;
    @(negedge clk);
    vecs++;
    if (ctl !== E_REDIR) begin errs++; $display("FAIL branch_ctl got=%b exp=%b", ctl, E_REDIR); end
    vecs++;
    if (redirect_pc !== 32'h8000_0040) begin errs++; $display("FAIL branch_pc got=%h exp=80000040", redirect_pc); end
    step();
    br_taken_e = 1'b0; br_target_e = 32'hDEAD_BEEF;
    @(negedge clk);
    vecs++;
    if (ctl !== E_NONE) begin errs++; $display("FAIL branch_pulse got=%b exp=%b", ctl, E_NONE); end
    vecs++;
    if (redirect_pc !== 32'h0) begin errs++; $display("FAIL branch_pc_after got=%h exp=0", redirect_pc); end
    step();
  endtask

  task automatic test_branch_drain();
    logic [9:0] exp_c [5];
    word_t      exp_p [5];
    exp_c = '{E_REDIR, E_DRAIN, E_DRAIN, E_DRAIN, E_NONE};
    exp_p = '{32'h0000_1F00, 32'h0000_1F00, 32'h0000_1F00, 32'h0000_1F00, 32'h0};
    for (int i = 0; i < 5; i++) begin
      br_taken_e  = (i == 0);
      br_target_e = (i == 0) ? 32'h0000_1F00 : 32'hFFFF_0000;
      imem_busy   = (i < 3);
      @(negedge clk);
      vecs++;
      if (ctl !== exp_c[i]) begin errs++; $display("FAIL drain_ctl cyc%0d got=%b exp=%b", i, ctl, exp_c[i]); end
      vecs++;
      if (redirect_pc !== exp_p[i]) begin errs++; $display("FAIL drain_pc cyc%0d got=%h exp=%h", i, redirect_pc, exp_p[i]); end
      step();
    end
    br_target_e = '0;
    vecs++;
    if (stall_cnt !== 5'd1) begin errs++; $display("FAIL drain_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_muldiv();
    logic [9:0] exp_c [6];
    exp_c = '{E_MD, E_MD, E_MD, E_MD, E_DONE, E_NONE};
    for (int i = 0; i < 6; i++) begin
      md_start_e = (i < 5);
      @(negedge clk);
      vecs++;
      if (ctl !== exp_c[i]) begin errs++; $display("FAIL muldiv cyc%0d got=%b exp=%b", i, ctl, exp_c[i]); end
      step();
    end
    vecs++;
    if (stall_cnt !== 5'd5) begin errs++; $display("FAIL muldiv_cnt got=%0d exp=5", stall_cnt); end
  endtask

  task automatic test_md_freeze();
    logic [9:0] exp_c [8];
    exp_c = '{E_MD, E_MD, E_FZ, E_FZ, E_MD, E_MD, E_DONE, E_NONE};
    for (int i = 0; i < 8; i++) begin
      md_start_e  = (i < 7);
      dmem_busy_m = (i == 2) || (i == 3);
      @(negedge clk);
      vecs++;
      if (ctl !== exp_c[i]) begin errs++; $display("FAIL md_freeze cyc%0d got=%b exp=%b", i, ctl, exp_c[i]); end
      step();
    end
    dmem_busy_m = 1'b0;
    vecs++;
    if (stall_cnt !== 5'd11) begin errs++; $display("FAIL md_freeze_cnt got=%0d exp=11", stall_cnt); end
  endtask

  task automatic test_done_freeze();
    logic [9:0] exp_c [7];
    exp_c = '{E_MD, E_MD, E_MD, E_MD, E_FZD, E_DONE, E_NONE};
    for (int i = 0; i < 7; i++) begin
      md_start_e  = (i < 6);
      dmem_busy_m = (i == 4);
      @(negedge clk);
      vecs++;
      if (ctl !== exp_c[i]) begin errs++; $display("FAIL done_freeze cyc%0d got=%b exp=%b", i, ctl, exp_c[i]); end
      step();
    end
    dmem_busy_m = 1'b0;
    vecs++;
    if (stall_cnt !== 5'd16) begin errs++; $display("FAIL done_freeze_cnt got=%0d exp=16", stall_cnt); end
  endtask

  task automatic test_priority();
    logic [9:0] exp_c [5];
    word_t      exp_p [5];
    exp_c = '{E_REDIR, E_FW, E_FZ, E_REDIR, E_NONE};
    exp_p = '{32'hA000_0000, 32'h0, 32'h0, 32'hB000_0004, 32'h0};
    for (int i = 0; i < 5; i++) begin
      br_taken_e  = (i == 0) || (i == 2) || (i == 3);
      br_target_e = (i == 0) ? 32'hA000_0000 : 32'hB000_0004;
      bubble_rs2  = (i == 0);
      imem_busy   = (i == 1);
      dmem_busy_m = (i == 2);
      @(negedge clk);
      vecs++;
      if (ctl !== exp_c[i]) begin errs++; $display("FAIL priority cyc%0d got=%b exp=%b", i, ctl, exp_c[i]); end
      vecs++;
      if (redirect_pc !== exp_p[i]) begin errs++; $display("FAIL priority_pc cyc%0d got=%h exp=%h", i, redirect_pc, exp_p[i]); end
      step();
    end
    vecs++;
    if (stall_cnt !== 5'd18) begin errs++; $display("FAIL priority_cnt got=%0d exp=18", stall_cnt); end
  endtask

  task automatic test_reset_drain();
    br_taken_e = 1'b1; br_target_e = 32'h0000_0C00; imem_busy = 1'b1;
    @(negedge clk);
    vecs++;
    if (ctl !== E_REDIR) begin errs++; $display("FAIL rst_drain_enter got=%b exp=%b", ctl, E_REDIR); end
    step();
    br_taken_e = 1'b0;
    @(negedge clk);
    vecs++;
    if (ctl !== E_DRAIN) begin errs++; $display("FAIL rst_drain_state got=%b exp=%b", ctl, E_DRAIN); end
    #1 resetn = 1'b0;
    #1;
    vecs++;
    if (ctl !== E_NONE) begin errs++; $display("FAIL rst_drain_ctl got=%b exp=%b", ctl, E_NONE); end
    vecs++;
    if (redirect_pc !== 32'h0) begin errs++; $display("FAIL rst_drain_pc got=%h exp=0", redirect_pc); end
    vecs++;
    if (stall_cnt !== 5'd0) begin errs++; $display("FAIL rst_drain_cnt got=%0d exp=0", stall_cnt); end
    step();
    resetn = 1'b1;
    @(negedge clk);
    vecs++;
    if (ctl !== E_FW) begin errs++; $display("FAIL rst_drain_run got=%b exp=%b", ctl, E_FW); end
    vecs++;
    if (redirect_pc !== 32'h0) begin errs++; $display("FAIL rst_drain_noreplay got=%h exp=0", redirect_pc); end
    step();
  endtask

  task automatic test_saturation();
    // One stall_f cycle from the post-reset fetch wait is already counted.
    imem_busy = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      step();
      if (i == 29) begin
        vecs++;
        if (stall_cnt !== 5'd30) begin errs++; $display("FAIL sat_30 got=%0d exp=30", stall_cnt); end
      end
      if (i == 30) begin
        vecs++;
        if (stall_cnt !== 5'd31) begin errs++; $display("FAIL sat_31 got=%0d exp=31", stall_cnt); end
      end
      if (i == 35) begin
        vecs++;
        if (stall_cnt !== 5'd31) begin errs++; $display("FAIL sat_hold got=%0d exp=31", stall_cnt); end
      end
    end
    imem_busy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_branch_drain();
    test_muldiv();
    test_md_freeze();
    test_done_freeze();
    test_priority();
    test_reset_drain();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control unit for the five-stage (F/D/E/M/W) core. It collects hazard and stall sources and turns them into per-stage hold and bubble-insert controls plus a fetch redirect. The sources are:
- load-use bubble requests from the two decode-stage operand forwarding muxes (rs1/rs2);
- taken-branch/jump resolution in E;
- outstanding instruction- and data-bus handshakes;
- multi-cycle mul/div occupancy.

It sits beside the stage registers and owns every stall/flush decision in the core.

## Interface
- `MD_LAT`, default 64: cycles a mul/div instruction occupies E, including the start cycle. Must be ≥ 1.
- `CNT_W`, default 32: width of the stall-cycle performance counter.

Ports:
- `clk`  in  1  core clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `bubble_rs1`, `bubble_rs2`  in  1  load-use request from the D-stage forwarding muxes.
- `br_taken_e`  in  1  instruction in E redirects control flow.
- `br_target_e`  in  word_t  redirect target.
- `imem_busy`  in  1  fetch request outstanding (valid && !data_ok).
- `dmem_busy_m`  in  1  M-stage data access not yet complete.
- `md_start_e`  in  1  E holds a mul/div; level, held while the instruction stays in E.
- `stall_f`, `stall_d`, `stall_e`, `stall_m`  out  1  hold the stage register.
- `flush_d`, `flush_e`, `flush_m`, `flush_w`  out  1  load a bubble into the stage register.
- `redirect_valid`  out  1  PC must load `redirect_pc`.
- `redirect_pc`  out  word_t  redirect target.
- `md_done`  out  1  mul/div result valid in E this cycle.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `stall_f`=1.

## Operation
- States:
  - RUN.
  - MD_WAIT: E occupied by mul/div, with down-counter `md_cnt`.
  - FETCH_DRAIN: redirect pending behind an in-flight fetch.
- Rules are evaluated in priority order each cycle. The first matching rule drives the outputs; all other controls are 0.
  1. `dmem_busy_m`: `stall_f`/`stall_d`/`stall_e`/`stall_m`=1, `flush_w`=1. State and `md_cnt` are frozen; no transitions.
  2. MD_WAIT: `stall_f`/`stall_d`/`stall_e`=1, `flush_m`=1.
     - `md_cnt` decrements.
     - At `md_cnt`==1: go to RUN and set `md_done_q`.
  3. FETCH_DRAIN: `redirect_valid`=1 with the registered `redirect_pc`, `flush_d`=1, `stall_f`=0. When `imem_busy`=0, return to RUN.
  4. RUN, `br_taken_e`: `flush_d`=1, `flush_e`=1, `redirect_valid`=1, `redirect_pc`=`br_target_e`; the target is registered.
     - If `imem_busy` is also 1, go to FETCH_DRAIN.
     - The redirect has priority over load-use, because the dependent instruction is squashed anyway.
  5. RUN, `md_start_e` && !`md_done_q`: apply rule-2 outputs this cycle.
     - If `MD_LAT`>1: go to MD_WAIT with `md_cnt`=`MD_LAT`-1.
     - If `MD_LAT`==1: set `md_done_q` and stay in RUN.
  6. RUN, `bubble_rs1`|`bubble_rs2`: `stall_f`=1, `stall_d`=1, `flush_e`=1.
  7. RUN, `imem_busy`: `stall_f`=1, `flush_d`=1.
- `md_done`:
  - `md_done` = `md_done_q`. It is set on the cycle E is released and is high for exactly one cycle, then clears.
  - While set, it masks `md_start_e` so the departing instruction does not re-trigger.
  - If `dmem_busy_m` is high while `md_done_q` is set, `md_done_q` holds until the freeze lifts.
- `stall_cnt` increments on every cycle with `stall_f`=1 and saturates at all-ones.

## Timing
- Reset (async assert, sync release):
  - State is RUN; `md_cnt`, `md_done_q`, the redirect register and `stall_cnt` are 0.
  - All stall/flush outputs, `redirect_valid`, `redirect_pc` and `md_done` are 0.
- Outputs are combinational from the current inputs plus registered state (zero-latency stall decision). State updates on `posedge clk`.
- A mul/div holds E for exactly `MD_LAT` cycles, with `md_done`=1 on cycle `MD_LAT`+1 as the instruction leaves E.
- Redirect with no fetch in flight: `redirect_valid` is a single-cycle pulse.
- Redirect with a fetch in flight: `redirect_valid` is held until the cycle `imem_busy` falls, inclusive. The stale instruction returned that cycle is bubbled by `flush_d`.
- A `br_taken_e` arriving while `dmem_busy_m` is high is acted on in the first cycle after the freeze lifts; E is held, so the input persists.
- Reset mid-MD_WAIT or mid-FETCH_DRAIN discards the pending work; no redirect is replayed.

## Structure
- `pipe_state_t` (enum RUN/MD_WAIT/FETCH_DRAIN) and the stage-control struct (`stall`/`flush` per stage) go in the `pipes` package; `word_t` comes from `common`.
- One natural sub-module: `md_timer`, holding the `md_cnt` load/decrement logic and the `md_done_q` flag.

## Test plan
- Load-use: `bubble_rs1`=1 for 1 cycle in RUN → `stall_f`=`stall_d`=`flush_e`=1 for that cycle only; `stall_cnt` reads 1.
- Branch with no fetch in flight: `br_taken_e`=1, `br_target_e`=0x8000_0040 → one-cycle `redirect_valid`, `redirect_pc`=0x8000_0040, `flush_d`=`flush_e`=1.
- Branch with a fetch in flight: `br_taken_e` with `imem_busy`=1, where `imem_busy` falls 3 cycles later → `redirect_valid`/`flush_d` high for 4 cycles; state returns to RUN.
- Mul/div: `MD_LAT`=4, `md_start_e` held → `stall_e`=1 for exactly 4 cycles, then `md_done`=1 for 1 cycle; no re-trigger while `md_start_e` is still high.
- Freeze during mul/div: `dmem_busy_m`=1 for 2 cycles mid-MD_WAIT (`MD_LAT`=4) → all stalls asserted and `md_cnt` frozen; total E occupancy is 6 cycles.
- Priority and reset: `br_taken_e` and `bubble_rs2` together → redirect outputs only, no `stall_d`. Then `resetn`=0 during FETCH_DRAIN → all outputs 0 immediately, state RUN after release.
